mode_select: RTL and testbench

MODE_SELECT -- requirements
Module: mode_select

---
 rtl/mode_select.sv | 104 ++++++++++
 tb/tb_mode_select.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mode_select.sv
// Two-button mode stepper: synchronize, debounce, press/auto-repeat, wrap-around mode.
// Mode updates DB_LIMIT+3 edges after a clean raw press; lock discards steps, counters keep running.
module mode_select #(
   parameter int DB_LIMIT      = 20,
   parameter int REPEAT_CYCLES = 1000,
   parameter int NUM_MODES     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       lock,
   output logic [1:0] mode,
   output logic       mode_changed
);

   localparam logic [7:0]  DB_LAST   = 8'(DB_LIMIT - 1);
   localparam logic [15:0] RPT_LAST  = 16'(REPEAT_CYCLES - 1);
   localparam logic [1:0]  MODE_LAST = 2'(NUM_MODES - 1);

   // Index 0 is btn_next, index 1 is btn_prev.
   logic [1:0]  raw;
   logic [1:0]  sync1;
   logic [1:0]  sync2;
   logic [1:0]  db;
   logic [1:0]  db_q;
   logic [7:0]  db_cnt  [2];
   logic [15:0] rep_cnt [2];
   logic [1:0]  press;
   logic [1:0]  rep_evt;
   logic        any_press;
   logic        next_evt;
   logic        prev_evt;
   logic [1:0]  mode_nx;
   logic        step;

   assign raw = {btn_prev, btn_next};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         press[i]   = db[i] & ~db_q[i];
         rep_evt[i] = db[i] & db_q[i] & (rep_cnt[i] == RPT_LAST);
      end
   end

   assign any_press = |press;
   assign next_evt  = press[0] | rep_evt[0];
   assign prev_evt  = press[1] | rep_evt[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_q  <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i]  <= '0;
            rep_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         db_q  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
            // Either button's press restarts both repeat timers so they stay phase-aligned.
            if (!db[i] || any_press || rep_evt[i])
               rep_cnt[i] <= '0;
            else
               rep_cnt[i] <= rep_cnt[i] + 16'd1;
         end
      end
   end

   always_comb begin
      mode_nx = mode;
      step    = 1'b0;
      if (!lock && (next_evt != prev_evt)) begin
         step = 1'b1;
         if (next_evt)
            mode_nx = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
         else
            mode_nx = (mode == 2'd0) ? MODE_LAST : mode - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode         <= 2'd0;
         mode_changed <= 1'b0;
      end else begin
         mode         <= mode_nx;
         mode_changed <= step;
      end
   end

endmodule

// File: tb/tb_mode_select.sv
// Bench for mode_select: table of button operations plus hand-written latency, bounce,
// auto-repeat and reset-abandon sequences; a queue scoreboard checks every mode_changed pulse.
module tb_mode_select;

   localparam int DBL = 4;
   localparam int RPT = 10;
   localparam int NM  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_next;
   logic       btn_prev;
   logic       lock;
   logic [1:0] mode;
   logic       mode_changed;

   always #5 clk = ~clk;

   mode_select #(.DB_LIMIT(DBL), .REPEAT_CYCLES(RPT), .NUM_MODES(NM)) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_next     (btn_next),
      .btn_prev     (btn_prev),
      .lock         (lock),
      .mode         (mode),
      .mode_changed (mode_changed)
   );

   typedef struct {
      logic       nxt;
      logic       prv;
      logic       lck;
      logic [1:0] exp_mode;
   } vec_t;

   vec_t       tbl [10];
   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   logic [1:0] exp_q [$];
   int         chg_q [$];
   logic [1:0] model_mode;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check("mode_range", 32'(mode < 2'(NM)), 32'd1);
      if (mode_changed === 1'b1) begin
         chg_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_step: got mode %0d, want no step", mode);
         end else begin
            check("sb_mode", 32'(mode), 32'(exp_q.pop_front()));
         end
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic press_op(input logic nxt, input logic prv);
      btn_next = nxt;
      btn_prev = prv;
      ticks(8);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      ticks(12);
   endtask

   initial begin
      int t0;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd2};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd2};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 2'd0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd2};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 2'd2};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 2'd2};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 2'd2};
      tbl[9] = '{1'b0, 1'b1, 1'b0, 2'd1};

      rst      = 1'b1;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      lock     = 1'b0;
      ticks(3);
      check("reset_mode", 32'(mode), 32'd0);
      check("reset_changed", 32'(mode_changed), 32'd0);

      // Button held through reset release: step lands on edge DBL+3.
      btn_next = 1'b1;
      rst      = 1'b0;
      exp_q.push_back(2'd1);
      ticks(DBL + 2);
      check("basic_before_mode", 32'(mode), 32'd0);
      check("basic_before_changed", 32'(mode_changed), 32'd0);
      tick();
      check("basic_mode", 32'(mode), 32'd1);
      check("basic_changed", 32'(mode_changed), 32'd1);
      tick();
      check("basic_changed_one_cycle", 32'(mode_changed), 32'd0);
      btn_next = 1'b0;
      ticks(12);
      model_mode = 2'd1;

      for (int i = 0; i < 10; i++) begin
         lock = tbl[i].lck;
         if (tbl[i].exp_mode != model_mode)
            exp_q.push_back(tbl[i].exp_mode);
         press_op(tbl[i].nxt, tbl[i].prv);
         lock = 1'b0;
         check("tbl_mode", 32'(mode), 32'(tbl[i].exp_mode));
         check("tbl_sb_drained", 32'(exp_q.size()), 32'd0);
         model_mode = tbl[i].exp_mode;
      end

      // Bounce: toggling every 2 cycles never stays stable for DBL samples.
      for (int k = 0; k < 20; k++) begin
         btn_next = ~btn_next;
         ticks(2);
      end
      btn_next = 1'b0;
      ticks(15);
      check("bounce_mode", 32'(mode), 32'(model_mode));

      // Auto-repeat: one press step then three repeat steps, RPT cycles apart.
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      chg_q.delete();
      t0 = cyc;
      btn_next = 1'b1;
      ticks(36);
      btn_next = 1'b0;
      ticks(15);
      check("rpt_steps", 32'(chg_q.size()), 32'd4);
      if (chg_q.size() == 4) begin
         check("rpt_first_latency", 32'(chg_q[0] - t0), 32'(DBL + 3));
         for (int i = 1; i < 4; i++)
            check("rpt_period", 32'(chg_q[i] - chg_q[i-1]), 32'(RPT));
      end
      check("rpt_mode", 32'(mode), 32'd2);
      check("rpt_sb_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-debounce (counter at 2), then release with button still held.
      btn_next = 1'b1;
      ticks(4);
      rst = 1'b1;
      #1;
      check("rst_mid_mode", 32'(mode), 32'd0);
      check("rst_mid_changed", 32'(mode_changed), 32'd0);
      ticks(2);
      rst = 1'b0;
      exp_q.push_back(2'd1);
      ticks(DBL + 2);
      check("rst_rel_before", 32'(mode), 32'd0);
      tick();
      check("rst_rel_mode", 32'(mode), 32'd1);
      check("rst_rel_changed", 32'(mode_changed), 32'd1);
      btn_next = 1'b0;
      ticks(12);
      check("rst_sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
